// File: rtl/mips_pkg.sv
// Shared constants, opcodes and loader state type for the MIPS FPGA system.
// Imported by the loader, the core and the top level.
package mips_pkg;

    localparam int NB_DATA      = 32;
    localparam int NB_BYTE      = 8;
    localparam int NB_IMEM_ADDR = 8;

    localparam logic [NB_DATA-1:0] HALT_WORD = 32'hF400_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_HALT  = 6'h3D;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [NB_BYTE-1:0] CMD_LOAD   = 8'h4C;
    localparam logic [NB_BYTE-1:0] CMD_EXEC   = 8'h45;
    localparam logic [NB_BYTE-1:0] ACK_LOADED = 8'h4B;
    localparam logic [NB_BYTE-1:0] ACK_DONE   = 8'h44;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_t;

endpackage

// File: rtl/mips_core.sv
// Single-cycle MIPS subset core with a loader-writable instruction memory.
// While stalled the PC is parked at 0, so every run starts from address 0.
module mips_core
    import mips_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    stall_i,
    input  logic                    imem_we_i,
    input  logic [NB_IMEM_ADDR-1:0] imem_addr_i,
    input  logic [NB_DATA-1:0]      imem_wdata_i,
    output logic                    halt_o
);

    logic [NB_DATA-1:0] imem_q [2**NB_IMEM_ADDR];
    logic [NB_DATA-1:0] regs_q [32];
    logic [NB_DATA-1:0] pc_q, pc_d, pc4, instr, rs_v, rt_v, imm_s, wval;
    logic [5:0]         op, fn;
    logic [4:0]         wreg;
    logic               wen;

    assign instr = imem_q[pc_q[NB_IMEM_ADDR+1:2]];
    assign op    = instr[31:26];
    assign fn    = instr[5:0];
    assign rs_v  = regs_q[instr[25:21]];
    assign rt_v  = regs_q[instr[20:16]];
    assign imm_s = {{16{instr[15]}}, instr[15:0]};
    assign pc4   = pc_q + 32'd4;

    always_comb begin
        pc_d   = pc4;
        wen    = 1'b0;
        wreg   = instr[20:16];
        wval   = '0;
        halt_o = 1'b0;
        case (op)
            OP_RTYPE: begin
                wen  = 1'b1;
                wreg = instr[15:11];
                case (fn)
                    FN_SLL:           wval = rt_v << instr[10:6];
                    FN_SRL:           wval = rt_v >> instr[10:6];
                    FN_ADD, FN_ADDU:  wval = rs_v + rt_v;
                    FN_SUB, FN_SUBU:  wval = rs_v - rt_v;
                    FN_AND:           wval = rs_v & rt_v;
                    FN_OR:            wval = rs_v | rt_v;
                    FN_SLT:           wval = {31'd0, $signed(rs_v) < $signed(rt_v)};
                    FN_JR: begin
                        wen  = 1'b0;
                        pc_d = rs_v;
                    end
                    default:          wen = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                wen  = 1'b1;
                wval = rs_v + imm_s;
            end
            OP_SLTI: begin
                wen  = 1'b1;
                wval = {31'd0, $signed(rs_v) < $signed(imm_s)};
            end
            OP_ORI: begin
                wen  = 1'b1;
                wval = rs_v | {16'd0, instr[15:0]};
            end
            OP_BEQ: if (rs_v == rt_v) pc_d = pc4 + {imm_s[29:0], 2'b00};
            OP_BNE: if (rs_v != rt_v) pc_d = pc4 + {imm_s[29:0], 2'b00};
            OP_J:   pc_d = {pc4[31:28], instr[25:0], 2'b00};
            OP_JAL: begin
                pc_d = {pc4[31:28], instr[25:0], 2'b00};
                wen  = 1'b1;
                wreg = 5'd31;
                wval = pc4;
            end
            OP_HALT: begin
                pc_d   = pc_q;
                halt_o = !stall_i && (instr == HALT_WORD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (imem_we_i) imem_q[imem_addr_i] <= imem_wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (stall_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (wen && wreg != 5'd0) regs_q[wreg] <= wval;
        end
    end

endmodule

// File: rtl/mips_loader_top_fsm.sv
// Loader FSM: command decode, big-endian byte packing, imem writes and status flags.
// All outputs are registered.
module loader_fsm
    import mips_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    rx_valid_i,
    input  logic [NB_BYTE-1:0]      rx_data_i,
    input  logic                    core_halt_i,
    output logic                    imem_we_o,
    output logic [NB_IMEM_ADDR-1:0] imem_addr_o,
    output logic [NB_DATA-1:0]      imem_data_o,
    output logic                    core_stall_o,
    output logic                    tx_req_o,
    output logic [NB_BYTE-1:0]      tx_data_o,
    output logic                    loaded_o,
    output logic                    ended_o,
    output logic                    load_error_o,
    output loader_state_t           state_o
);

    loader_state_t           state_q;
    logic [NB_IMEM_ADDR:0]   wr_addr_q;
    logic [NB_IMEM_ADDR-1:0] waddr_q;
    logic [1:0]              byte_cnt_q;
    logic [NB_DATA-1:0]      word_q, word_d;
    logic [NB_BYTE-1:0]      tx_data_q;
    logic                    we_q, stall_q, tx_req_q, loaded_q, ended_q, err_q;
    logic                    start_load, start_exec;

    assign word_d     = {word_q[NB_DATA-NB_BYTE-1:0], rx_data_i};
    assign start_load = rx_valid_i && rx_data_i == CMD_LOAD &&
                        (state_q == ST_IDLE || state_q == ST_READY || state_q == ST_DONE);
    assign start_exec = rx_valid_i && rx_data_i == CMD_EXEC &&
                        (state_q == ST_READY || state_q == ST_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            waddr_q    <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            tx_data_q  <= '0;
            we_q       <= 1'b0;
            stall_q    <= 1'b1;
            tx_req_q   <= 1'b0;
            loaded_q   <= 1'b0;
            ended_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q     <= 1'b0;
            tx_req_q <= 1'b0;
            if (start_load) begin
                state_q    <= ST_LOAD;
                wr_addr_q  <= '0;
                byte_cnt_q <= '0;
                loaded_q   <= 1'b0;
                ended_q    <= 1'b0;
                err_q      <= 1'b0;
            end else if (start_exec) begin
                state_q <= ST_RUN;
                stall_q <= 1'b0;
                ended_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_LOAD: if (rx_valid_i) begin
                        word_q     <= word_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        // Top bit of wr_addr set means imem is already full
                        if (byte_cnt_q == 2'd3 && wr_addr_q[NB_IMEM_ADDR]) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (byte_cnt_q == 2'd3) begin
                            we_q      <= 1'b1;
                            waddr_q   <= wr_addr_q[NB_IMEM_ADDR-1:0];
                            wr_addr_q <= wr_addr_q + 1'b1;
                            if (word_d == HALT_WORD) begin
                                loaded_q  <= 1'b1;
                                tx_req_q  <= 1'b1;
                                tx_data_q <= ACK_LOADED;
                                state_q   <= ST_READY;
                            end
                        end
                    end
                    ST_RUN: if (core_halt_i) begin
                        stall_q   <= 1'b1;
                        ended_q   <= 1'b1;
                        tx_req_q  <= 1'b1;
                        tx_data_q <= ACK_DONE;
                        state_q   <= ST_DONE;
                    end
                    ST_IDLE, ST_READY, ST_DONE: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = waddr_q;
    assign imem_data_o  = word_q;
    assign core_stall_o = stall_q;
    assign tx_req_o     = tx_req_q;
    assign tx_data_o    = tx_data_q;
    assign loaded_o     = loaded_q;
    assign ended_o      = ended_q;
    assign load_error_o = err_q;
    assign state_o      = state_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver; pulses valid_o for one cycle per received byte.
// Samples each bit at its centre after a two-flop synchroniser.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       valid_o,
    output logic [7:0] data_o
);

    logic        s1_q, s2_q, busy_q, valid_q;
    logic [15:0] cnt_q;
    logic [3:0]  bit_q;
    logic [7:0]  sh_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            s1_q    <= rx_i;
            s2_q    <= s1_q;
            valid_q <= 1'b0;
            if (!busy_q) begin
                if (!s2_q) begin
                    busy_q <= 1'b1;
                    cnt_q  <= 16'(CLKS_PER_BIT / 2);
                    bit_q  <= '0;
                end
            end else if (cnt_q != 16'd0) begin
                cnt_q <= cnt_q - 16'd1;
            end else begin
                cnt_q <= 16'(CLKS_PER_BIT - 1);
                bit_q <= bit_q + 4'd1;
                if (bit_q == 4'd0) begin
                    busy_q <= ~s2_q;
                end else if (bit_q == 4'd9) begin
                    busy_q  <= 1'b0;
                    valid_q <= s2_q;
                end else begin
                    sh_q <= {s2_q, sh_q[7:1]};
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = sh_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; start_i is accepted only while busy_o is low.
// Line idles high, LSB first.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       tx_o
);

    logic        busy_q, tx_q;
    logic [15:0] cnt_q;
    logic [3:0]  bit_q;
    logic [8:0]  sh_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '1;
        end else if (!busy_q) begin
            if (start_i) begin
                busy_q <= 1'b1;
                tx_q   <= 1'b0;
                sh_q   <= {1'b1, data_i};
                cnt_q  <= 16'(CLKS_PER_BIT - 1);
                bit_q  <= '0;
            end
        end else if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
        end else if (bit_q == 4'd9) begin
            busy_q <= 1'b0;
        end else begin
            tx_q  <= sh_q[0];
            sh_q  <= {1'b1, sh_q[8:1]};
            bit_q <= bit_q + 4'd1;
            cnt_q <= 16'(CLKS_PER_BIT - 1);
        end
    end

    assign busy_o = busy_q;
    assign tx_o   = tx_q;

endmodule

// File: rtl/mips_loader_top.sv
// FPGA top: UART program loader, MIPS core and status reporting.
// Wires loader_fsm, uart_rx, uart_tx and mips_core.
module mips_loader_top
    import mips_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_uart_rx,
    input  logic       i_test,
    output logic       o_uart_tx,
    output logic       o_program_loaded,
    output logic       o_program_ended,
    output logic [7:0] o_leds,
    output logic       o_test
);

    logic                    rx_valid, imem_we, stall, halt;
    logic                    tx_req, tx_busy, tx_start, err;
    logic [NB_BYTE-1:0]      rx_data, tx_req_data;
    logic [NB_IMEM_ADDR-1:0] imem_addr;
    logic [NB_DATA-1:0]      imem_data;
    loader_state_t           state;
    logic                    tx_pend_q, test_q;
    logic [NB_BYTE-1:0]      tx_data_q;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i   (i_clock),
        .rst_ni  (i_reset),
        .rx_i    (i_uart_rx),
        .valid_o (rx_valid),
        .data_o  (rx_data)
    );

    loader_fsm u_fsm (
        .clk_i        (i_clock),
        .rst_ni       (i_reset),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .core_halt_i  (halt),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_data_o  (imem_data),
        .core_stall_o (stall),
        .tx_req_o     (tx_req),
        .tx_data_o    (tx_req_data),
        .loaded_o     (o_program_loaded),
        .ended_o      (o_program_ended),
        .load_error_o (err),
        .state_o      (state)
    );

    mips_core u_core (
        .clk_i        (i_clock),
        .rst_ni       (i_reset),
        .stall_i      (stall),
        .imem_we_i    (imem_we),
        .imem_addr_i  (imem_addr),
        .imem_wdata_i (imem_data),
        .halt_o       (halt)
    );

    // One-deep TX queue; a newer request replaces a pending one
    assign tx_start = tx_pend_q && !tx_busy;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tx_pend_q <= 1'b0;
            tx_data_q <= '0;
            test_q    <= 1'b0;
        end else begin
            test_q <= i_test;
            if (tx_req) begin
                tx_pend_q <= 1'b1;
                tx_data_q <= tx_req_data;
            end else if (tx_start) begin
                tx_pend_q <= 1'b0;
            end
        end
    end

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk_i   (i_clock),
        .rst_ni  (i_reset),
        .start_i (tx_start),
        .data_i  (tx_data_q),
        .busy_o  (tx_busy),
        .tx_o    (o_uart_tx)
    );

    assign o_leds = {1'b0, state, err, o_program_ended,
                     state == ST_RUN, o_program_loaded};
    assign o_test = test_q;

endmodule

// File: tb/tb_mips_loader_top.sv
// Directed bench: UART load, execute, flags, LEDs, TX acks and test loopback.
module tb_mips_loader_top;

    localparam int CLKS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx = 1'b1;
    logic       test_in = 1'b0;
    logic       tx, loaded, ended, test_out;
    logic [7:0] leds;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] txq[$];

    logic [31:0] prog [18] = '{
        32'h20010005, 32'h20020000, 32'h20030001, 32'h2004000b, 32'h201f0000,
        32'h0061282a, 32'h10050002, 32'h20630001, 32'h08000005, 32'h00431021,
        32'h0c00000e, 32'h20070045, 32'h2042000a, 32'h08000010, 32'h2042000a,
        32'h03e00008, 32'h40000000, 32'hf4000000
    };

    mips_loader_top #(.CLKS_PER_BIT(CLKS)) dut (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .i_uart_rx        (rx),
        .i_test           (test_in),
        .o_uart_tx        (tx),
        .o_program_loaded (loaded),
        .o_program_ended  (ended),
        .o_leds           (leds),
        .o_test           (test_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CLKS + 4) @(negedge clk);
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp);
        int          t;
        logic [31:0] got;
        t = 0;
        while (txq.size() == 0 && t < 40 * CLKS) begin
            @(negedge clk);
            t++;
        end
        got = (txq.size() == 0) ? 32'hDEAD_0000 : {24'd0, txq.pop_front()};
        chk(tag, got, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge tx);
            repeat (CLKS / 2) @(posedge clk);
            if (tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKS) @(posedge clk);
                    b[i] = tx;
                end
                repeat (CLKS) @(posedge clk);
                txq.push_back(b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_loaded", loaded, 0);
        chk("rst_ended", ended, 0);
        chk("rst_leds", leds, 0);
        chk("rst_tx", tx, 1);
        chk("rst_test", test_out, 0);
        chk("rst_wr_addr", dut.u_fsm.wr_addr_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send_byte(8'h45);
        chk("idle_E_leds", leds, 8'h00);
        chk("idle_E_ended", ended, 0);

        send_byte(8'h4C);
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h05);
        chk("w0_imem", dut.u_core.imem_q[0], 32'h20010005);
        chk("w0_wr_addr", dut.u_fsm.wr_addr_q, 1);
        chk("w0_loaded", loaded, 0);
        chk("w0_leds", leds, 8'h10);

        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        chk("midload_rst_leds", leds, 8'h00);
        chk("midload_rst_wr_addr", dut.u_fsm.wr_addr_q, 0);
        chk("midload_rst_byte_cnt", dut.u_fsm.byte_cnt_q, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send_byte(8'h4C);
        for (int i = 0; i < 18; i++) begin
            for (int k = 3; k >= 0; k--) begin
                send_byte(prog[i][8*k +: 8]);
                if (i == 17 && k == 1) chk("pre_halt_loaded", loaded, 0);
            end
        end
        chk("load_loaded", loaded, 1);
        chk("load_leds", leds, 8'h21);
        chk("load_wr_addr", dut.u_fsm.wr_addr_q, 18);
        chk("load_imem9", dut.u_core.imem_q[9], 32'h00431021);
        chk("load_imem17", dut.u_core.imem_q[17], 32'hF4000000);
        wait_tx("tx_K", 8'h4B);

        send_byte(8'h45);
        t = 0;
        while (ended !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("run_ended", ended, 1);
        chk("run_leds", leds, 8'h45);
        chk("run_r1", dut.u_core.regs_q[1], 32'd5);
        chk("run_r2", dut.u_core.regs_q[2], 32'd25);
        chk("run_r3", dut.u_core.regs_q[3], 32'd5);
        chk("run_r7", dut.u_core.regs_q[7], 32'h45);
        chk("run_r31", dut.u_core.regs_q[31], 32'd44);
        wait_tx("tx_D", 8'h44);

        @(negedge clk);
        test_in = 1'b1;
        #1;
        chk("test_before_edge", test_out, 0);
        @(negedge clk);
        chk("test_rise", test_out, 1);
        test_in = 1'b0;
        @(negedge clk);
        chk("test_fall", test_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
